// File: rtl/fft_fp4_pkg.sv
// Shared FP4 types and helpers for the radix-2 DIT FFT datapath.
// FP4 is sign-magnitude: bit 3 is the sign, bits 2:0 are the magnitude code.
// Only 0, 0.5 and 1.0 are used. Zero is always encoded as +0.
package fft_fp4_pkg;

    typedef logic [3:0] fp4_t;

    localparam fp4_t FP4_ZERO     = 4'b0000;
    localparam fp4_t FP4_HALF     = 4'b0001;
    localparam fp4_t FP4_ONE      = 4'b0010;
    localparam int   FP4_SIGN_BIT = 3;

    typedef struct packed {
        fp4_t re;
        fp4_t im;
    } tw_byte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Negation that never produces -0.
    function automatic fp4_t fp4_neg(input fp4_t x);
        fp4_t r;
        r = x;
        if (x[2:0] != 3'b000) begin
            r[FP4_SIGN_BIT] = ~x[FP4_SIGN_BIT];
        end
        return r;
    endfunction

    // Quantised cos(2*pi*i/max_n) for the first quadrant, in integer arithmetic
    // so it folds at elaboration. acos(0.75) = 41.409 deg, acos(0.25) = 75.522 deg;
    // angle in millidegrees is i*360000/max_n.
    function automatic fp4_t fp4_cos_q(input int i, input int max_n);
        if (i * 360000 <= 41409 * max_n) begin
            return FP4_ONE;
        end else if (i * 360000 <= 75522 * max_n) begin
            return FP4_HALF;
        end
        return FP4_ZERO;
    endfunction

endpackage

// File: rtl/twiddle_seq_gen_if.sv
// Twiddle output stream: valid/ready with per-lane valid mask and last flag.
//   master (generator): drives tw_valid, tw_data, tw_lane_vld, tw_last
//   slave  (consumer) : drives tw_ready
interface twiddle_seq_gen_if #(
    parameter int LANES = 1
) ();
    logic                 tw_valid;
    logic                 tw_ready;
    logic [8*LANES-1:0]   tw_data;
    logic [LANES-1:0]     tw_lane_vld;
    logic                 tw_last;

    modport master (
        output tw_valid, tw_data, tw_lane_vld, tw_last,
        input  tw_ready
    );

    modport slave (
        input  tw_valid, tw_data, tw_lane_vld, tw_last,
        output tw_ready
    );
endinterface

// File: rtl/twiddle_qrom.sv
// Quarter-wave twiddle table with reflection, purely combinational.
// Ports:
//   k_i  : index k' on the MAX_N scale (top two bits are the quadrant)
//   tw_o : {q(cos theta), q(-sin theta)}, theta = 2*pi*k'/MAX_N
module twiddle_qrom
    import fft_fp4_pkg::*;
#(
    parameter int MAX_N      = 32,
    parameter int LOG2_MAX_N = $clog2(MAX_N)
) (
    input  logic [LOG2_MAX_N-1:0] k_i,
    output tw_byte_t              tw_o
);
    localparam int QB = LOG2_MAX_N - 2;
    localparam int Q  = MAX_N / 4;

    fp4_t ctab [0:Q];
    for (genvar i = 0; i <= Q; i++) begin : g_tab
        assign ctab[i] = fp4_cos_q(i, MAX_N);
    end

    logic [1:0]  quad;
    logic [QB:0] r;
    logic [QB:0] qmr;
    fp4_t        c_r;
    fp4_t        c_qr;

    assign quad = k_i[LOG2_MAX_N-1 -: 2];
    assign r    = {1'b0, k_i[QB-1:0]};
    assign qmr  = (QB+1)'(Q) - r;
    assign c_r  = ctab[r];
    assign c_qr = ctab[qmr];

    // sin(r) = cos(Q-r) inside a quadrant; imag is the negated sine.
    always_comb begin
        tw_o = '{re: FP4_ZERO, im: FP4_ZERO};
        case (quad)
            2'd0: tw_o = '{re: c_r,           im: fp4_neg(c_qr)};
            2'd1: tw_o = '{re: fp4_neg(c_qr), im: fp4_neg(c_r)};
            2'd2: tw_o = '{re: fp4_neg(c_r),  im: c_qr};
            default: tw_o = '{re: c_qr,       im: c_r};
        endcase
    end
endmodule

// File: rtl/twiddle_seq_gen.sv
// Streaming twiddle-factor generator for one radix-2 DIT FFT stage.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   start              : command strobe, accepted only in IDLE
//   log2_n, stage      : FFT size N = 2^log2_n, stage s (span m = 2^(s+1))
//   inverse            : conjugate twiddles, only with TW_INVERSE_EN defined
//   tw (master)        : output stream, LANES factors per beat
//   busy, done, err    : status (done / err are 1-cycle pulses)
// Optional feature macro: TW_INVERSE_EN.
//
// state | meaning
// IDLE  | waiting for a command
// RUN   | issuing beats into the pipeline
// DRAIN | last beat issued, waiting for its handshake
module twiddle_seq_gen
    import fft_fp4_pkg::*;
#(
    parameter int MAX_N      = 32,
    parameter int LOG2_MAX_N = $clog2(MAX_N),
    parameter int LANES      = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [LOG2_MAX_N:0]   log2_n,
    input  logic [LOG2_MAX_N-1:0] stage,
`ifdef TW_INVERSE_EN
    input  logic                  inverse,
`endif
    twiddle_seq_gen_if.master     tw,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int LW = LOG2_MAX_N;
    localparam logic [LW:0] L2N_MAX = (LW+1)'(LW);

    state_t                  state_q, state_d;
    logic [LW-1:0]           beat_q, beat_d;
    logic [LW-1:0]           stage_q, stage_d;
    logic                    done_q, err_q;
    logic                    inv_q;

    logic                    v1_q, last1_q;
    logic [LANES-1:0]        lv1_q;
    logic [LANES-1:0][LW-1:0] k1_q;

    logic                    v2_q, last2_q;
    logic [LANES-1:0]        lv2_q;
    logic [8*LANES-1:0]      d2_q;

    logic cmd_bad, accept, reject, issue, hs, adv1, adv2;
    logic [LW-1:0]            iss_beat, iss_stage;
    logic [LANES-1:0]         iss_lv;
    logic [LANES-1:0][LW-1:0] iss_k;
    logic                     iss_last;

    // Stage 2 may advance when empty or when its beat is taken; stage 1
    // advances whenever stage 2 can take its content.
    assign hs   = v2_q && tw.tw_ready;
    assign adv2 = !v2_q || tw.tw_ready;
    assign adv1 = !v1_q || adv2;

    assign cmd_bad = (log2_n == '0) || (log2_n > L2N_MAX) || ({1'b0, stage} >= log2_n);
    // A start on the done cycle is dropped, valid or not.
    assign accept  = (state_q == IDLE) && start && !done_q && !cmd_bad;
    assign reject  = (state_q == IDLE) && start && !done_q && cmd_bad;
    assign issue   = accept || ((state_q == RUN) && adv1);

    // Beat 0 is issued on the accepting edge so the first beat is out two cycles later.
    assign iss_beat  = (state_q == IDLE) ? '0 : beat_q;
    assign iss_stage = (state_q == IDLE) ? stage : stage_q;

    always_comb begin
        int s_i, sh, jb, j, nb;
        s_i = int'(iss_stage);
        if (s_i > LW - 1) s_i = LW - 1;
        sh  = LW - 1 - s_i;
        nb  = ((1 << s_i) + LANES - 1) / LANES;
        jb  = int'(iss_beat) * LANES;
        j   = 0;
        iss_last = (int'(iss_beat) == nb - 1);
        iss_lv   = '0;
        iss_k    = '0;
        for (int l = 0; l < LANES; l++) begin
            j = jb + l;
            if (j < (1 << s_i)) begin
                iss_lv[l] = 1'b1;
                iss_k[l]  = LW'(j << sh);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            stage_q <= stage_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        stage_d = stage_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stage_d = stage;
                    beat_d  = LW'(1);
                    state_d = iss_last ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (adv1) begin
                    beat_d = beat_q + LW'(1);
                    if (iss_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs && last2_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef TW_INVERSE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      inv_q <= 1'b0;
        else if (accept) inv_q <= inverse;
    end
`else
    assign inv_q = 1'b0;
`endif

    tw_byte_t [LANES-1:0]    rom_tw;
    logic [8*LANES-1:0]      s2_data;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        twiddle_qrom #(
            .MAX_N      (MAX_N),
            .LOG2_MAX_N (LOG2_MAX_N)
        ) u_qrom (
            .k_i  (k1_q[l]),
            .tw_o (rom_tw[l])
        );
        assign s2_data[8*l +: 8] = lv1_q[l]
            ? {rom_tw[l].re, (inv_q ? fp4_neg(rom_tw[l].im) : rom_tw[l].im)}
            : 8'h00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            last1_q <= 1'b0;
            lv1_q   <= '0;
            k1_q    <= '0;
            v2_q    <= 1'b0;
            last2_q <= 1'b0;
            lv2_q   <= '0;
            d2_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (adv1) begin
                v1_q    <= issue;
                last1_q <= issue && iss_last;
                lv1_q   <= issue ? iss_lv : '0;
                k1_q    <= iss_k;
            end
            if (adv2) begin
                v2_q    <= v1_q;
                last2_q <= last1_q;
                lv2_q   <= lv1_q;
                d2_q    <= s2_data;
            end
            done_q <= hs && last2_q;
            err_q  <= reject;
        end
    end

    assign tw.tw_valid    = v2_q;
    assign tw.tw_data     = d2_q;
    assign tw.tw_lane_vld = lv2_q;
    assign tw.tw_last     = last2_q;
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err            = err_q;
endmodule

// File: tb/tb_twiddle_seq_gen.sv
module tb_twiddle_seq_gen;
    localparam int MAX_N = 32;
    localparam int LW    = 5;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  lv;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start4 = 1'b0;
    logic [LW:0]   log2_n = '0;
    logic [LW-1:0] stage  = '0;
    logic inv = 1'b0;
    logic busy1, done1, err1, busy4, done4, err4;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];
    logic [31:0] obs [64];
    logic [31:0] ref16 [16];
    int nobs = 0;

    always #5 clk = ~clk;

    twiddle_seq_gen_if #(.LANES(1)) if1 ();
    twiddle_seq_gen_if #(.LANES(4)) if4 ();

    twiddle_seq_gen #(.MAX_N(MAX_N), .LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .log2_n(log2_n), .stage(stage),
`ifdef TW_INVERSE_EN
        .inverse(inv),
`endif
        .tw(if1), .busy(busy1), .done(done1), .err(err1)
    );

    twiddle_seq_gen #(.MAX_N(MAX_N), .LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .log2_n(log2_n), .stage(stage),
`ifdef TW_INVERSE_EN
        .inverse(inv),
`endif
        .tw(if4), .busy(busy4), .done(done4), .err(err4)
    );

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, o, e);
        end
    endtask

    function automatic logic [3:0] q4(input real x);
        real a;
        logic [2:0] mag;
        a = (x < 0.0) ? -x : x;
        mag = (a >= 0.75) ? 3'd2 : ((a >= 0.25) ? 3'd1 : 3'd0);
        if (mag == 3'd0) return 4'h0;
        return {(x < 0.0), mag};
    endfunction

    function automatic logic [7:0] exp_tw(input int j, input int m, input logic iv);
        real th;
        th = 2.0 * 3.141592653589793 * j / m;
        return {q4($cos(th)), (iv ? q4($sin(th)) : q4(-$sin(th)))};
    endfunction

    task automatic run_cmd(input int which, input int l2n, input int stg,
                           input bit rnd, input bit lat, input bit sod);
        int lanes, m, half, nb, cyc, first, j;
        exp_t e;
        bit held;
        logic [37:0] held_w;
        logic rdy, v, l;
        logic [31:0] d;
        logic [3:0] lv;
        lanes = (which != 0) ? 4 : 1;
        m = 1 << (stg + 1);
        half = m / 2;
        nb = (half + lanes - 1) / lanes;
        sb.delete();
        nobs = 0;
        for (int b = 0; b < nb; b++) begin
            e = '0;
            for (int ln = 0; ln < lanes; ln++) begin
                j = b * lanes + ln;
                if (j < half) begin
                    e.data[8*ln +: 8] = exp_tw(j, m, inv);
                    e.lv[ln] = 1'b1;
                end
            end
            e.last = (b == nb - 1);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        log2_n = (LW+1)'(l2n);
        stage  = LW'(stg);
        if (which != 0) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        chk("busy_after_start", (which != 0) ? busy4 : busy1, 1);
        cyc = 0; first = -1; held = 0; held_w = '0;
        while (sb.size() > 0 && cyc < 400) begin
            rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if1.tw_ready = rdy;
            if4.tw_ready = rdy;
            @(negedge clk);
            v  = (which != 0) ? if4.tw_valid : if1.tw_valid;
            l  = (which != 0) ? if4.tw_last  : if1.tw_last;
            d  = (which != 0) ? if4.tw_data  : {24'h0, if1.tw_data};
            lv = (which != 0) ? if4.tw_lane_vld : {3'b0, if1.tw_lane_vld};
            if (held) begin
                chk("stall_hold", {v, l, lv, d}, held_w);
                held = 0;
            end
            if (v && first < 0) first = cyc;
            if (v && rdy) begin
                e = sb.pop_front();
                chk("beat_data", d, e.data);
                chk("beat_lane_vld", lv, e.lv);
                chk("beat_last", l, e.last);
                obs[nobs] = d;
                nobs++;
            end else if (v) begin
                held = 1;
                held_w = {v, l, lv, d};
            end
            @(posedge clk); #1;
            cyc++;
        end
        if1.tw_ready = 1'b1;
        if4.tw_ready = 1'b1;
        chk("beats_remaining", sb.size(), 0);
        if (lat) chk("first_valid_latency", first, 1);
        chk("done_pulse", (which != 0) ? done4 : done1, 1);
        chk("busy_after_done", (which != 0) ? busy4 : busy1, 0);
        chk("valid_after_done", (which != 0) ? if4.tw_valid : if1.tw_valid, 0);
        if (sod) begin
            if (which != 0) start4 = 1'b1; else start1 = 1'b1;
        end
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        chk("done_one_cycle", (which != 0) ? done4 : done1, 0);
        if (sod) begin
            chk("start_on_done_ignored", (which != 0) ? busy4 : busy1, 0);
            chk("start_on_done_no_err", (which != 0) ? err4 : err1, 0);
            @(posedge clk); #1;
            chk("start_on_done_no_valid", (which != 0) ? if4.tw_valid : if1.tw_valid, 0);
        end
    endtask

    task automatic err_cmd(input int which, input int l2n, input int stg);
        @(posedge clk); #1;
        log2_n = (LW+1)'(l2n);
        stage  = LW'(stg);
        if (which != 0) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        chk("err_pulse", (which != 0) ? err4 : err1, 1);
        chk("err_busy", (which != 0) ? busy4 : busy1, 0);
        @(posedge clk); #1;
        chk("err_one_cycle", (which != 0) ? err4 : err1, 0);
        chk("err_no_valid", (which != 0) ? if4.tw_valid : if1.tw_valid, 0);
        chk("err_still_idle", (which != 0) ? busy4 : busy1, 0);
    endtask

    initial begin
        if1.tw_ready = 1'b1;
        if4.tw_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", if1.tw_valid, 0);
        chk("rst_data", if1.tw_data, 0);
        chk("rst_last", if1.tw_last, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_err", err1, 0);
        chk("rst_valid4", if4.tw_valid, 0);
        rst_n = 1'b1;

        // N=32, last stage: 16 beats, full rate
        run_cmd(0, 5, 4, 0, 1, 0);
        chk("beats_case1", nobs, 16);
        for (int i = 0; i < 16; i++) ref16[i] = obs[i];
        chk("j0", obs[0], 32'h20);
        chk("j2", obs[2], 32'h29);
        chk("j4", obs[4], 32'h19);
        chk("j8", obs[8], 32'h0A);
        chk("j12", obs[12], 32'h99);

        // stage 0: single beat, start during done pulse ignored
        run_cmd(0, 5, 0, 0, 1, 1);
        chk("stage0_beat", obs[0], 32'h20);

        // 4 lanes, stage 1: one partial beat
        run_cmd(1, 5, 1, 0, 1, 0);
        chk("lanes4_stage1", obs[0], 32'h0000_0A20);
        run_cmd(1, 5, 0, 0, 1, 0);
        run_cmd(1, 5, 4, 1, 1, 0);
        run_cmd(1, 5, 3, 1, 0, 0);

        // random stalls must reproduce the full-rate sequence
        run_cmd(0, 5, 4, 1, 1, 0);
        for (int i = 0; i < 16; i++) chk("stall_vs_case1", obs[i], ref16[i]);

        // smaller runtime N
        run_cmd(0, 4, 2, 1, 1, 0);
        run_cmd(0, 3, 0, 0, 1, 0);

        // rejected commands
        err_cmd(0, 6, 0);
        err_cmd(0, 3, 3);
        err_cmd(1, 0, 0);

        // reset in the middle of a stream
        @(posedge clk); #1;
        log2_n = 6'd5; stage = 5'd4; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("pre_rst_valid", if1.tw_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", if1.tw_valid, 0);
        chk("midrst_data", if1.tw_data, 0);
        chk("midrst_lane_vld", if1.tw_lane_vld, 0);
        chk("midrst_last", if1.tw_last, 0);
        chk("midrst_busy", busy1, 0);
        chk("midrst_done", done1, 0);
        chk("midrst_err", err1, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_cmd(0, 5, 4, 0, 1, 0);
        for (int i = 0; i < 16; i++) chk("after_rst_seq", obs[i], ref16[i]);

`ifdef TW_INVERSE_EN
        inv = 1'b1;
        run_cmd(0, 5, 4, 0, 1, 0);
        chk("inv_j8", obs[8], 32'h02);
        chk("inv_j4", obs[4], 32'h11);
        chk("inv_j0", obs[0], 32'h20);
        inv = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
